boot_sequencer: RTL and testbench



---
 rtl/boot_sequencer_pkg.sv | 23 ++
 rtl/boot_load_port.sv | 31 +++
 rtl/boot_sequencer.sv | 179 +++++++++++++++++
 tb/tb_boot_sequencer.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/boot_sequencer_pkg.sv
// Shared constants and FSM state type for the boot sequencer.
// The CHECK state exists only when BOOT_SEQ_CHECKSUM_EN is defined.
package boot_sequencer_pkg;

  localparam int unsigned BOOT_WIDTH       = 16;
  localparam int unsigned BOOT_INSTR_DEPTH = 32;
  localparam int unsigned BOOT_DATA_DEPTH  = 16;
  localparam int unsigned BOOT_INSTR_AW    = $clog2(BOOT_INSTR_DEPTH);
  localparam int unsigned BOOT_DATA_AW     = $clog2(BOOT_DATA_DEPTH);
  localparam int unsigned BOOT_RUN_W       = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_I,
    S_LOAD_D,
`ifdef BOOT_SEQ_CHECKSUM_EN
    S_CHECK,
`endif
    S_RUN,
    S_DONE
  } boot_state_e;

endpackage

// File: rtl/boot_load_port.sv
// Registered write stage for one CPU load port: strobe follows the request by
// one cycle, and address/data hold their last written value between strobes.
module boot_load_port #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned AW    = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             write_en,
  input  logic [AW-1:0]    write_addr,
  input  logic [WIDTH-1:0] write_data,
  output logic             strobe,
  output logic [AW-1:0]    addr,
  output logic [WIDTH-1:0] data
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      strobe <= 1'b0;
      addr   <= '0;
      data   <= '0;
    end else begin
      strobe <= write_en;
      if (write_en) begin
        addr <= write_addr;
        data <= write_data;
      end
    end
  end

endmodule

// File: rtl/boot_sequencer.sv
// Boot sequencer: loads instruction/data memories from a host stream, then runs
// the CPU for a programmed number of cycles. Optional feature: BOOT_SEQ_CHECKSUM_EN.
module boot_sequencer
  import boot_sequencer_pkg::*;
#(
  parameter int unsigned WIDTH       = BOOT_WIDTH,
  parameter int unsigned INSTR_DEPTH = BOOT_INSTR_DEPTH,
  parameter int unsigned DATA_DEPTH  = BOOT_DATA_DEPTH,
  parameter int unsigned RUN_W       = BOOT_RUN_W,
  localparam int unsigned IAW = $clog2(INSTR_DEPTH),
  localparam int unsigned DAW = $clog2(DATA_DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [RUN_W-1:0] run_len,
  input  logic             host_valid,
  input  logic [WIDTH-1:0] host_data,
  output logic             host_ready,
  output logic             cpu_reset,
  output logic             load_instr,
  output logic [IAW-1:0]   load_instr_address,
  output logic [WIDTH-1:0] instruction_input,
  output logic             load_data,
  output logic [DAW-1:0]   load_data_address,
  output logic [WIDTH-1:0] data_input,
  output logic             busy,
  output logic             done,
  output logic             error
);

  localparam logic [IAW-1:0] I_LAST = IAW'(INSTR_DEPTH - 1);
  localparam logic [IAW-1:0] D_LAST = IAW'(DATA_DEPTH - 1);

  boot_state_e      state, state_nxt;
  logic [IAW-1:0]   word_cnt;
  logic [RUN_W-1:0] run_len_q;
  logic [RUN_W-1:0] run_cnt;
  logic             hs;
  logic             clr;
  logic             instr_we;
  logic             data_we;

  assign hs = host_valid & host_ready;

`ifdef BOOT_SEQ_CHECKSUM_EN
  logic [WIDTH-1:0] csum;
  logic             err_q;
  logic             set_err;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    host_ready = 1'b0;
    cpu_reset  = 1'b1;
    busy       = 1'b1;
    done       = 1'b0;
    clr        = 1'b0;
    instr_we   = 1'b0;
    data_we    = 1'b0;
`ifdef BOOT_SEQ_CHECKSUM_EN
    set_err    = 1'b0;
`endif
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) begin
          state_nxt = S_LOAD_I;
          clr       = 1'b1;
        end
      end
      S_LOAD_I: begin
        host_ready = 1'b1;
        instr_we   = hs;
        if (hs && word_cnt == I_LAST) state_nxt = S_LOAD_D;
      end
      S_LOAD_D: begin
        host_ready = 1'b1;
        data_we    = hs;
        if (hs && word_cnt == D_LAST) begin
`ifdef BOOT_SEQ_CHECKSUM_EN
          state_nxt = S_CHECK;
`else
          state_nxt = S_RUN;
`endif
        end
      end
`ifdef BOOT_SEQ_CHECKSUM_EN
      S_CHECK: begin
        host_ready = 1'b1;
        if (hs) begin
          if (host_data == csum) begin
            state_nxt = S_RUN;
          end else begin
            state_nxt = S_DONE;
            set_err   = 1'b1;
          end
        end
      end
`endif
      // First RUN cycle keeps the CPU in reset while the last data strobe lands.
      S_RUN: begin
        cpu_reset = (run_cnt == '0);
        if (run_cnt == run_len_q) state_nxt = S_DONE;
      end
      S_DONE: begin
        busy = 1'b0;
        done = 1'b1;
        if (start) begin
          state_nxt = S_LOAD_I;
          clr       = 1'b1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      word_cnt  <= '0;
      run_len_q <= '0;
      run_cnt   <= '0;
    end else begin
      if (clr) begin
        word_cnt  <= '0;
        run_len_q <= run_len;
      end else if (instr_we || data_we) begin
        word_cnt <= (state_nxt == state) ? word_cnt + 1'b1 : '0;
      end
      run_cnt <= (state == S_RUN) ? run_cnt + 1'b1 : '0;
    end
  end

`ifdef BOOT_SEQ_CHECKSUM_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      csum  <= '0;
      err_q <= 1'b0;
    end else if (clr) begin
      csum  <= '0;
      err_q <= 1'b0;
    end else begin
      if (instr_we || data_we) csum <= csum + host_data;
      if (set_err) err_q <= 1'b1;
    end
  end
  assign error = err_q;
`else
  assign error = 1'b0;
`endif

  boot_load_port #(.WIDTH(WIDTH), .AW(IAW)) u_instr_port (
    .clk        (clk),
    .reset      (reset),
    .write_en   (instr_we),
    .write_addr (word_cnt),
    .write_data (host_data),
    .strobe     (load_instr),
    .addr       (load_instr_address),
    .data       (instruction_input)
  );

  boot_load_port #(.WIDTH(WIDTH), .AW(DAW)) u_data_port (
    .clk        (clk),
    .reset      (reset),
    .write_en   (data_we),
    .write_addr (word_cnt[DAW-1:0]),
    .write_data (host_data),
    .strobe     (load_data),
    .addr       (load_data_address),
    .data       (data_input)
  );

endmodule

// File: tb/tb_boot_sequencer.sv
// Directed self-checking bench for boot_sequencer; covers the checksum path
// when built with BOOT_SEQ_CHECKSUM_EN.
`timescale 1ns/1ps
module tb_boot_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  run_len = '0;
  logic        host_valid = 1'b0;
  logic [15:0] host_data = '0;
  logic        host_ready, cpu_reset, load_instr, load_data, busy, done, error;
  logic [4:0]  load_instr_address;
  logic [3:0]  load_data_address;
  logic [15:0] instruction_input, data_input;

  int n_vec = 0;
  int n_err = 0;
  int ib, db, lc;
`ifdef BOOT_SEQ_CHECKSUM_EN
  logic [15:0] exp_sum;
`endif

  always #5 clk = ~clk;

  boot_sequencer #(.WIDTH(16), .INSTR_DEPTH(32), .DATA_DEPTH(16), .RUN_W(8)) dut (
    .clk                (clk),
    .reset              (reset),
    .start              (start),
    .run_len            (run_len),
    .host_valid         (host_valid),
    .host_data          (host_data),
    .host_ready         (host_ready),
    .cpu_reset          (cpu_reset),
    .load_instr         (load_instr),
    .load_instr_address (load_instr_address),
    .instruction_input  (instruction_input),
    .load_data          (load_data),
    .load_data_address  (load_data_address),
    .data_input         (data_input),
    .busy               (busy),
    .done               (done),
    .error              (error)
  );

  // Strobe recorder: every write seen by the memories, plus CPU-released cycles.
  logic [20:0] iq[$];
  logic [19:0] dq[$];
  int low_cnt = 0;
  always @(negedge clk) begin
    if (load_instr) iq.push_back({load_instr_address, instruction_input});
    if (load_data)  dq.push_back({load_data_address, data_input});
    if (!cpu_reset) low_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [15:0] d);
    int   waited = 0;
    logic acc = 1'b0;
    host_valid = 1'b1;
    host_data  = d;
    while (!acc && waited < 64) begin
      acc = host_ready;
      step(1);
      waited++;
    end
    host_valid = 1'b0;
    chk("send_accepted", {31'b0, acc}, 1);
  endtask

  task automatic gap(input int n);
    repeat (n) begin
      start = ($urandom_range(0, 1) == 1);
      run_len = 8'h77;
      step(1);
      start = 1'b0;
    end
  endtask

  task automatic boot(input logic [7:0] rl, input logic [15:0] base, input bit incr, input bit gaps);
    logic [15:0] w;
    start   = 1'b1;
    run_len = rl;
    step(1);
    start   = 1'b0;
    run_len = 8'hA5;
`ifdef BOOT_SEQ_CHECKSUM_EN
    exp_sum = '0;
`endif
    for (int i = 0; i < 48; i++) begin
      if (gaps) gap($urandom_range(0, 3));
      w = incr ? base + 16'(i) : base;
`ifdef BOOT_SEQ_CHECKSUM_EN
      exp_sum = exp_sum + w;
`endif
      send(w);
    end
  endtask

  task automatic finish_load();
`ifdef BOOT_SEQ_CHECKSUM_EN
    send(exp_sum);
`endif
  endtask

  task automatic wait_done(input int budget);
    int k = 0;
    while (!done && k < budget) begin
      step(1);
      k++;
    end
    chk("done_reached", {31'b0, done}, 1);
    chk("done_cpu_reset", {31'b0, cpu_reset}, 1);
    chk("done_busy", {31'b0, busy}, 0);
  endtask

  task automatic check_load(input int ibase, input int dbase, input logic [15:0] base);
    chk("instr_count", iq.size() - ibase, 32);
    chk("data_count", dq.size() - dbase, 16);
    for (int i = 0; i < 32; i++)
      if (ibase + i < iq.size())
        chk($sformatf("instr[%0d]", i), {11'b0, iq[ibase + i]}, {11'b0, 5'(i), base + 16'(i)});
    for (int i = 0; i < 16; i++)
      if (dbase + i < dq.size())
        chk($sformatf("data[%0d]", i), {12'b0, dq[dbase + i]}, {12'b0, 4'(i), base + 16'(32 + i)});
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_host_ready"}, {31'b0, host_ready}, 0);
    chk({tag, "_cpu_reset"}, {31'b0, cpu_reset}, 1);
    chk({tag, "_load_instr"}, {31'b0, load_instr}, 0);
    chk({tag, "_load_data"}, {31'b0, load_data}, 0);
    chk({tag, "_instr_addr"}, {27'b0, load_instr_address}, 0);
    chk({tag, "_data_addr"}, {28'b0, load_data_address}, 0);
    chk({tag, "_instr_in"}, {16'b0, instruction_input}, 0);
    chk({tag, "_data_in"}, {16'b0, data_input}, 0);
    chk({tag, "_busy"}, {31'b0, busy}, 0);
    chk({tag, "_done"}, {31'b0, done}, 0);
    chk({tag, "_error"}, {31'b0, error}, 0);
  endtask

  initial begin
    // Reset with the host already presenting data.
    host_valid = 1'b1;
    host_data  = 16'hDEAD;
    step(3);
    check_reset_values("rst");
    reset = 1'b1;
    step(3);
    check_reset_values("idle");
    chk("idle_no_strobes", iq.size() + dq.size(), 0);
    host_valid = 1'b0;

    // Back-to-back full load, run_len 5.
    ib = iq.size(); db = dq.size(); lc = low_cnt;
    boot(8'd5, 16'h0100, 1'b1, 1'b0);
`ifndef BOOT_SEQ_CHECKSUM_EN
    chk("run_entry_load_data", {31'b0, load_data}, 1);
    chk("run_entry_data_addr", {28'b0, load_data_address}, 15);
    chk("run_entry_data_in", {16'b0, data_input}, 16'h012F);
`endif
    finish_load();
    chk("run_entry_cpu_reset", {31'b0, cpu_reset}, 1);
    chk("run_entry_busy", {31'b0, busy}, 1);
    chk("run_entry_host_ready", {31'b0, host_ready}, 0);
    step(1);
    chk("run_released", {31'b0, cpu_reset}, 0);
    wait_done(40);
    chk("run5_low_cycles", low_cnt - lc, 5);
    chk("run5_error", {31'b0, error}, 0);
    check_load(ib, db, 16'h0100);

    // DONE ignores host words.
    ib = iq.size(); db = dq.size();
    host_valid = 1'b1;
    step(3);
    chk("done_host_ready", {31'b0, host_ready}, 0);
    host_valid = 1'b0;
    step(1);
    chk("done_no_strobes", (iq.size() - ib) + (dq.size() - db), 0);
    chk("done_held", {31'b0, done}, 1);

    // Host gaps with start pulses and run_len changes mid-load.
    ib = iq.size(); db = dq.size(); lc = low_cnt;
    boot(8'd3, 16'h0200, 1'b1, 1'b1);
    finish_load();
    wait_done(40);
    chk("gaps_low_cycles", low_cnt - lc, 3);
    check_load(ib, db, 16'h0200);

    // run_len 0: CPU never released.
    ib = iq.size(); db = dq.size(); lc = low_cnt;
    boot(8'd0, 16'h0400, 1'b1, 1'b0);
`ifndef BOOT_SEQ_CHECKSUM_EN
    chk("rl0_last_strobe", {31'b0, load_data}, 1);
`endif
    finish_load();
    chk("rl0_entry_cpu_reset", {31'b0, cpu_reset}, 1);
    chk("rl0_entry_done", {31'b0, done}, 0);
    step(1);
    chk("rl0_done", {31'b0, done}, 1);
    chk("rl0_cpu_reset", {31'b0, cpu_reset}, 1);
    chk("rl0_low_cycles", low_cnt - lc, 0);
    check_load(ib, db, 16'h0400);

    // Reset asserted 10 words into LOAD_I, then a clean reload.
    start   = 1'b1;
    run_len = 8'd9;
    step(1);
    start = 1'b0;
    for (int i = 0; i < 10; i++) send(16'h0500 + 16'(i));
    chk("midload_strobe", {31'b0, load_instr}, 1);
    reset = 1'b0;
    #1;
    check_reset_values("midrst");
    step(2);
    reset = 1'b1;
    step(1);
    chk("midrst_idle_busy", {31'b0, busy}, 0);
    ib = iq.size(); db = dq.size(); lc = low_cnt;
    boot(8'd2, 16'h0300, 1'b1, 1'b0);
    finish_load();
    wait_done(40);
    chk("reload_low_cycles", low_cnt - lc, 2);
    check_load(ib, db, 16'h0300);

`ifdef BOOT_SEQ_CHECKSUM_EN
    // Matching checksum: 48 words of 0x0001 sum to 0x0030.
    lc = low_cnt;
    boot(8'd4, 16'h0001, 1'b0, 1'b0);
    chk("cs_model_sum", {16'b0, exp_sum}, 32'h0030);
    send(16'h0030);
    wait_done(40);
    chk("cs_ok_low_cycles", low_cnt - lc, 4);
    chk("cs_ok_error", {31'b0, error}, 0);

    // Mismatching checksum: straight to DONE with error, CPU held.
    lc = low_cnt;
    boot(8'd4, 16'h0001, 1'b0, 1'b0);
    send(16'h0031);
    chk("cs_bad_done", {31'b0, done}, 1);
    chk("cs_bad_error", {31'b0, error}, 1);
    step(5);
    chk("cs_bad_cpu_reset", {31'b0, cpu_reset}, 1);
    chk("cs_bad_low_cycles", low_cnt - lc, 0);
    chk("cs_bad_error_held", {31'b0, error}, 1);
    start = 1'b1;
    step(1);
    start = 1'b0;
    chk("cs_error_cleared", {31'b0, error}, 0);
    chk("cs_restart_busy", {31'b0, busy}, 1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
